// File: rtl/dff_pkg.sv
// Shared limits and a legality check for the dff register/delay-line family.
// Pure elaboration-time content, no logic.
package dff_pkg;

    localparam int DFF_MIN_WIDTH  = 1;
    localparam int DFF_MIN_STAGES = 1;

    function automatic bit dff_params_legal(input int width, input int stages);
        return (width >= DFF_MIN_WIDTH) && (stages >= DFF_MIN_STAGES);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One WIDTH-bit register with synchronous active-low reset to RESET_VALUE.
// Latency 1 cycle; no backpressure, captures i on every edge out of reset.
module dff_stage #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= i;
        end
    end

    assign o = r_q;

endmodule

// File: rtl/dff.sv
// Parameterised register / delay line built from STAGES cascaded dff_stage flops.
// Latency STAGES cycles; no backpressure, all stages clear together on reset.
module dff
    import dff_pkg::*;
#(
    parameter int                 WIDTH       = 1,
    parameter int                 STAGES      = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o
);

    generate
        if (!dff_params_legal(WIDTH, STAGES)) begin : g_bad_params
            $fatal(1, "dff: WIDTH and STAGES must both be at least 1");
        end
    endgenerate

    // w_chain[0] is the input; w_chain[k] is the output of stage k-1.
    logic [WIDTH-1:0] w_chain [STAGES+1];

    assign w_chain[0] = i;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        dff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .i     (w_chain[g]),
            .o     (w_chain[g+1])
        );
    end

    assign o = w_chain[STAGES];

endmodule

// File: tb/tb_dff.sv
// Scoreboard bench for dff in three configurations sharing one clock and reset.
module tb_dff;

    typedef struct {
        int         idx;
        logic [0:0] e1;
        logic [7:0] e8;
        logic [0:0] e3;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [0:0] i1;
        logic [7:0] i8;
        logic [0:0] i3;
        logic       glitch;
        logic [0:0] e1;
        logic [7:0] e8;
        logic [0:0] e3;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [0:0] i1, o1;
    logic [7:0] i8, o8;
    logic [0:0] i3, o3;

    exp_t q[$];
    int   checks;
    int   errors;
    vec_t vecs[16];

    dff #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .i(i1), .o(o1)
    );
    dff #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'hA5)) u_dut8 (
        .clk(clk), .reset(reset), .i(i8), .o(o8)
    );
    dff #(.WIDTH(1), .STAGES(3), .RESET_VALUE(1'b0)) u_dut3 (
        .clk(clk), .reset(reset), .i(i3), .o(o3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: each falling edge shows the result of the preceding rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("o_w1s1", e.idx, {7'd0, o1}, {7'd0, e.e1});
            chk("o_w8",   e.idx, o8,         e.e8);
            chk("o_s3",   e.idx, {7'd0, o3}, {7'd0, e.e3});
        end
    end

    initial begin
        // rst, i1, i8, i3, glitch | expected o1, o8, o3 after the edge
        vecs[0]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        i1     = 1'b0;
        i8     = 8'h00;
        i3     = 1'b0;
        #2;

        // Inputs change 2 units after each rising edge, well clear of both edges.
        for (int k = 0; k < 16; k++) begin
            exp_t e;
            reset = vecs[k].rst;
            i1    = vecs[k].i1;
            i8    = vecs[k].i8;
            i3    = vecs[k].i3;
            e.idx = k;
            e.e1  = vecs[k].e1;
            e.e8  = vecs[k].e8;
            e.e3  = vecs[k].e3;
            q.push_back(e);
            if (vecs[k].glitch) begin
                #4;
                reset = 1'b0;
                i1    = 1'b0;
                i8    = 8'h00;
                i3    = 1'b1;
                #2;
                reset = vecs[k].rst;
                i1    = vecs[k].i1;
                i8    = vecs[k].i8;
                i3    = vecs[k].i3;
            end
            @(posedge clk);
            #2;
        end

        for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results never checked, required 0", q.size());
        end
        checks++;
        if (checks < 49) begin
            errors++;
            $display("FAIL count: %0d checks made, required 49", checks);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
